// File: rtl/day12_byte_packer.sv
// day12_byte_packer: packs a byte stream into little-endian 32-bit words, appends an end marker per frame, buffers in a FIFO
module day12_byte_packer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] END_MARKER = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic [15:0] word_count,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {S_FILL, S_END} state_t;
  state_t      r_state, w_state_nxt;
  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic [15:0] r_wcnt;
  logic        w_full, w_accept, w_pop, w_push_data, w_push_mark, w_push;
  logic [31:0] w_word, w_din;
  assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_accept    = s_valid && s_ready;
  assign w_pop       = m_valid && m_ready;
  assign w_push_data = w_accept && (r_lane == 2'd3 || s_last);
  // a pop in the same cycle frees the slot the marker needs
  assign w_push_mark = r_state == S_END && (!w_full || w_pop);
  assign w_push      = w_push_data || w_push_mark;
  assign w_word      = r_word | ({24'd0, s_data} << {r_lane, 3'd0});
  assign w_din       = w_push_mark ? END_MARKER : w_word;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == S_FILL && w_accept && s_last) ? S_END :
                  (r_state == S_END && w_push_mark)          ? S_FILL : r_state;
  end
  always_comb begin
    s_ready    = r_state == S_FILL && !w_full;
    m_valid    = r_count != '0;
    m_data     = m_valid ? r_mem[r_rd] : '0;
    word_count = r_wcnt;
    busy       = r_state == S_END || r_lane != 2'd0 || m_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_lane  <= '0;
      r_word  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_wcnt  <= '0;
    end else begin
      if (w_accept) begin
        r_lane <= w_push_data ? 2'd0 : r_lane + 2'd1;
        r_word <= w_push_data ? '0 : w_word;
      end
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_wcnt <= r_wcnt + 16'd1;
      end
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= w_din;
endmodule
